// File: rtl/rabi_sequencer.sv
// Rabi-oscillation pulse sequencer: per step ARM/laser-init/dead-time/RF/dead-time/readout,
// with the RF length swept by a saturating increment and optional per-step external triggering.
module rabi_sequencer #(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned STEP_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iABORT,
  input  logic              iTRIG,
  input  logic              iTRIG_EN,
  input  logic [CNT_W-1:0]  iLASER_LEN,
  input  logic [CNT_W-1:0]  iWAIT_LEN,
  input  logic [CNT_W-1:0]  iRF_BASE,
  input  logic [CNT_W-1:0]  iRF_INC,
  input  logic [CNT_W-1:0]  iREAD_LEN,
  input  logic [STEP_W-1:0] iNUM_STEPS,
  output logic              oRF,
  output logic              oLASER,
  output logic              oREADOUT,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [STEP_W-1:0] oSTEP
);

  typedef enum logic [2:0] {
    stIdle, stArm, stInit, stWait1, stRf, stWait2, stRead, stDone
  } seqState_t;

  seqState_t         state, nextState;
  logic [CNT_W-1:0]  phaseCnt, loadVal;
  logic [CNT_W-1:0]  laserLen, waitLen, rfLen, rfInc, readLen;
  logic [STEP_W-1:0] numSteps, stepIdx;
  logic              trigEn;
  logic              trigSync1, trigSync2, trigPrev, trigPulse;
  logic              phaseDone, lastStep, startAccept, stepAdvance;
  logic [CNT_W:0]    rfSum;
  logic [CNT_W-1:0]  rfNext;
  logic              rfD, laserD, readoutD, busyD, doneD;

  // A zero length still occupies one cycle, so the counter is loaded with max(L,1)-1.
  function automatic logic [CNT_W-1:0] phaseLoad(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign phaseDone   = (phaseCnt == '0);
  assign lastStep    = (stepIdx == numSteps - STEP_W'(1));
  assign startAccept = (state == stIdle) && iSTART && !iABORT;
  assign stepAdvance = (state == stRead) && (nextState == stArm);
  assign rfSum       = {1'b0, rfLen} + {1'b0, rfInc};
  assign rfNext      = rfSum[CNT_W] ? '1 : rfSum[CNT_W-1:0];

  // Trigger: two-flop synchronizer, then a registered rising edge accepted only while armed.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      trigSync1 <= 1'b0;
      trigSync2 <= 1'b0;
      trigPrev  <= 1'b0;
      trigPulse <= 1'b0;
    end else begin
      trigSync1 <= iTRIG;
      trigSync2 <= trigSync1;
      trigPrev  <= trigSync2;
      trigPulse <= trigSync2 && !trigPrev && (state == stArm);
    end
  end

  // State register, phase counter and latched run configuration.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state    <= stIdle;
      phaseCnt <= '0;
      laserLen <= '0;
      waitLen  <= '0;
      rfLen    <= '0;
      rfInc    <= '0;
      readLen  <= '0;
      numSteps <= '0;
      trigEn   <= 1'b0;
      stepIdx  <= '0;
    end else begin
      state <= nextState;
      if (nextState != state) phaseCnt <= loadVal;
      else if (!phaseDone)    phaseCnt <= phaseCnt - CNT_W'(1);
      if (startAccept) begin
        laserLen <= iLASER_LEN;
        waitLen  <= iWAIT_LEN;
        rfLen    <= iRF_BASE;
        rfInc    <= iRF_INC;
        readLen  <= iREAD_LEN;
        numSteps <= iNUM_STEPS;
        trigEn   <= iTRIG_EN;
        stepIdx  <= '0;
      end else if (stepAdvance) begin
        stepIdx <= stepIdx + STEP_W'(1);
        rfLen   <= rfNext;
      end
    end
  end

  // Next-state logic; abort overrides everything including a same-cycle start.
  always_comb begin
    nextState = state;
    case (state)
      stIdle:  if (iSTART) nextState = (iNUM_STEPS == '0) ? stDone : stArm;
      stArm:   if (!trigEn || trigPulse) nextState = stInit;
      stInit:  if (phaseDone) nextState = stWait1;
      stWait1: if (phaseDone) nextState = stRf;
      stRf:    if (phaseDone) nextState = stWait2;
      stWait2: if (phaseDone) nextState = stRead;
      stRead:  if (phaseDone) nextState = lastStep ? stDone : stArm;
      stDone:  nextState = stIdle;
      default: nextState = stIdle;
    endcase
    if (iABORT) nextState = stIdle;
  end

  // Counter preload for the phase about to be entered.
  always_comb begin
    loadVal = '0;
    case (nextState)
      stInit:           loadVal = phaseLoad(laserLen);
      stWait1, stWait2: loadVal = phaseLoad(waitLen);
      stRf:             loadVal = phaseLoad(rfLen);
      stRead:           loadVal = phaseLoad(readLen);
      default:          loadVal = '0;
    endcase
  end

  // Output decode from the next state so the registered drives line up with the state.
  always_comb begin
    rfD      = 1'b0;
    laserD   = 1'b0;
    readoutD = 1'b0;
    busyD    = (nextState != stIdle);
    doneD    = (nextState == stDone);
    case (nextState)
      stInit: laserD = 1'b1;
      stRf:   rfD    = 1'b1;
      stRead: begin
        laserD   = 1'b1;
        readoutD = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oRF      <= 1'b0;
      oLASER   <= 1'b0;
      oREADOUT <= 1'b0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oRF      <= rfD;
      oLASER   <= laserD;
      oREADOUT <= readoutD;
      oBUSY    <= busyD;
      oDONE    <= doneD;
    end
  end

  assign oSTEP = stepIdx;

endmodule

// File: tb/tb_rabi_sequencer.sv
// Scoreboard bench for rabi_sequencer: directed runs push expected pulse events,
// a negedge monitor measures pulse widths and pops/compares on every pulse end.
module tb_rabi_sequencer;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 16;
  localparam int KLASER = 0, KRF = 1, KREAD = 2, KDONE = 3;

  logic          iCLK = 1'b0, iRESET, iSTART, iABORT, iTRIG, iTRIG_EN;
  logic [CW-1:0] iLASER_LEN, iWAIT_LEN, iRF_BASE, iRF_INC, iREAD_LEN;
  logic [SW-1:0] iNUM_STEPS;
  logic          oRF, oLASER, oREADOUT, oBUSY, oDONE;
  logic [SW-1:0] oSTEP;

  rabi_sequencer #(.CNT_W(CW), .STEP_W(SW)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iABORT(iABORT),
    .iTRIG(iTRIG), .iTRIG_EN(iTRIG_EN), .iLASER_LEN(iLASER_LEN),
    .iWAIT_LEN(iWAIT_LEN), .iRF_BASE(iRF_BASE), .iRF_INC(iRF_INC),
    .iREAD_LEN(iREAD_LEN), .iNUM_STEPS(iNUM_STEPS), .oRF(oRF),
    .oLASER(oLASER), .oREADOUT(oREADOUT), .oBUSY(oBUSY), .oDONE(oDONE),
    .oSTEP(oSTEP)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int kind;
    int len;
    int step;
  } evt_t;

  evt_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   startCyc = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic popCheck(input int kind, input int len, input int step);
    evt_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind=%0d len=%0d step=%0d (cycle %0d)", kind, len, step, cyc);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.len != len || e.step != step) begin
        errors++;
        $display("FAIL event: got kind=%0d len=%0d step=%0d expected kind=%0d len=%0d step=%0d (cycle %0d)",
                 kind, len, step, e.kind, e.len, e.step, cyc);
      end
    end
  endtask

  // Monitor: measures each pulse width on its falling edge and checks it against the queue.
  int lasRun = 0, rfRun = 0, rdRun = 0;
  int lasStep = 0, rfStep = 0, rdStep = 0;
  always @(negedge iCLK) begin
    if (iRESET) begin
      lasRun = 0;
      rfRun  = 0;
      rdRun  = 0;
    end else begin
      if (oLASER) begin lasRun++; lasStep = int'(oSTEP); end
      else if (lasRun > 0) begin popCheck(KLASER, lasRun, lasStep); lasRun = 0; end
      if (oRF) begin rfRun++; rfStep = int'(oSTEP); end
      else if (rfRun > 0) begin popCheck(KRF, rfRun, rfStep); rfRun = 0; end
      if (oREADOUT) begin rdRun++; rdStep = int'(oSTEP); end
      else if (rdRun > 0) begin popCheck(KREAD, rdRun, rdStep); rdRun = 0; end
      if (oDONE) popCheck(KDONE, 1, int'(oSTEP));
      if (oRF) chk("rf_laser_overlap", int'(oLASER), 0);
    end
  end

  function automatic int atLeast1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic push(input int kind, input int len, input int step);
    evt_t e;
    e.kind = kind; e.len = len; e.step = step;
    expQ.push_back(e);
  endtask

  task automatic pushStep(input int step, input int laser, input int rf, input int rd);
    push(KLASER, atLeast1(laser), step);
    push(KRF, atLeast1(rf), step);
    push(KLASER, atLeast1(rd), step);
    push(KREAD, atLeast1(rd), step);
  endtask

  // Issues a one-cycle start, then scrambles the config inputs to prove they were latched.
  task automatic startRun(input bit trigEn, input int laser, input int waitL, input int base,
                          input int inc, input int rd, input int steps);
    @(negedge iCLK);
    iTRIG_EN = trigEn;
    iLASER_LEN = CW'(laser); iWAIT_LEN = CW'(waitL); iRF_BASE = CW'(base);
    iRF_INC = CW'(inc); iREAD_LEN = CW'(rd); iNUM_STEPS = SW'(steps);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    startCyc = cyc;
    iTRIG_EN = ~trigEn;
    iLASER_LEN = 8'd77; iWAIT_LEN = 8'd66; iRF_BASE = 8'd55;
    iRF_INC = 8'd44; iREAD_LEN = 8'd33; iNUM_STEPS = 16'd9;
  endtask

  task automatic waitDone(input string name, input int budget, input int expLat);
    int i;
    for (i = 0; i < budget; i++) begin
      if (oDONE) break;
      @(negedge iCLK);
    end
    if (i >= budget) chk({name, "_done_timeout"}, 0, 1);
    else if (expLat >= 0) chk({name, "_done_latency"}, cyc - startCyc, expLat);
    repeat (3) @(negedge iCLK);
    chk({name, "_queue_empty"}, expQ.size(), 0);
    chk({name, "_idle"}, int'(oBUSY), 0);
  endtask

  task automatic waitFor(input string name, input int budget, input int sel, input int stepv);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sel == 0 && oLASER) break;
      if (sel == 1 && oRF && int'(oSTEP) == stepv) break;
      if (sel == 2 && oREADOUT) break;
      if (sel == 3 && int'(oSTEP) == stepv) break;
      @(negedge iCLK);
    end
    if (i >= budget) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int t0;
    iRESET = 1'b1; iSTART = 1'b0; iABORT = 1'b0; iTRIG = 1'b0; iTRIG_EN = 1'b0;
    iLASER_LEN = '0; iWAIT_LEN = '0; iRF_BASE = '0; iRF_INC = '0; iREAD_LEN = '0;
    iNUM_STEPS = '0;
    repeat (2) @(negedge iCLK);
    chk("rst_rf", int'(oRF), 0);
    chk("rst_laser", int'(oLASER), 0);
    chk("rst_readout", int'(oREADOUT), 0);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_done", int'(oDONE), 0);
    chk("rst_step", int'(oSTEP), 0);
    iRESET = 1'b0;

    // Basic sweep: RF 4,6,8 with a stray start mid-run that must be ignored.
    for (int s = 0; s < 3; s++) pushStep(s, 10, 4 + 2 * s, 8);
    push(KDONE, 1, 2);
    startRun(1'b0, 10, 5, 4, 2, 8, 3);
    repeat (20) @(negedge iCLK);
    iNUM_STEPS = '0;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    waitDone("sweep", 300, 105);

    // All lengths zero, single step: every phase one cycle.
    pushStep(0, 0, 0, 0);
    push(KDONE, 1, 0);
    startRun(1'b0, 0, 0, 0, 0, 0, 1);
    waitDone("zero_len", 50, 6);

    // RF length saturates at the counter maximum.
    pushStep(0, 1, 253, 1);
    pushStep(1, 1, 255, 1);
    pushStep(2, 1, 255, 1);
    push(KDONE, 1, 2);
    startRun(1'b0, 1, 0, 253, 5, 1, 3);
    waitDone("saturate", 2000, 3 * (1 + 1 + 1 + 1 + 1 + 1) + 253 + 255 + 255 - 3);

    // Triggered run: wait for edge, held level must not start step 1, new edge does.
    pushStep(0, 3, 2, 2);
    pushStep(1, 3, 3, 2);
    push(KDONE, 1, 1);
    startRun(1'b1, 3, 2, 2, 1, 2, 2);
    repeat (50) @(negedge iCLK);
    chk("trig_armed_busy", int'(oBUSY), 1);
    iTRIG = 1'b1;
    t0 = cyc;
    waitFor("trig_first", 20, 0, 0);
    checks++;
    if (cyc - t0 < 3 || cyc - t0 > 4) begin
      errors++;
      $display("FAIL trig_latency: got %0d expected 3..4", cyc - t0);
    end
    waitFor("trig_step1_arm", 100, 3, 1);
    repeat (20) @(negedge iCLK);
    chk("trig_held_no_laser", int'(oLASER), 0);
    chk("trig_held_busy", int'(oBUSY), 1);
    iTRIG = 1'b0;
    repeat (3) @(negedge iCLK);
    iTRIG = 1'b1;
    waitDone("trig", 200, -1);
    iTRIG = 1'b0;

    // Abort during RF of step 1, then an immediate zero-step start.
    pushStep(0, 10, 4, 8);
    push(KLASER, 10, 1);
    push(KRF, 1, 1);
    startRun(1'b0, 10, 5, 4, 2, 8, 3);
    waitFor("abort_rf", 200, 1, 1);
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    chk("abort_rf_low", int'(oRF), 0);
    chk("abort_busy_low", int'(oBUSY), 0);
    chk("abort_no_done", int'(oDONE), 0);
    push(KDONE, 1, 0);
    iNUM_STEPS = '0;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    startCyc = cyc;
    waitDone("abort_restart", 20, 0);

    // Asynchronous reset in the middle of readout.
    pushStep(0, 10, 4, 8);
    startRun(1'b0, 10, 5, 4, 2, 8, 3);
    waitFor("rst_read", 200, 2, 0);
    #1 iRESET = 1'b1;
    expQ.delete();
    #1;
    chk("arst_rf", int'(oRF), 0);
    chk("arst_laser", int'(oLASER), 0);
    chk("arst_readout", int'(oREADOUT), 0);
    chk("arst_busy", int'(oBUSY), 0);
    chk("arst_step", int'(oSTEP), 0);
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    push(KDONE, 1, 0);
    startRun(1'b0, 5, 5, 5, 5, 5, 0);
    waitDone("zero_steps", 20, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
